icache_direct: RTL
==================

// Module: icache_direct
// PURPOSE
//  Direct-mapped instruction cache between ifetch and the memory controller.
//  Serves ifetch PC lookups: hit -> instruction 1 cycle later; miss -> issues a
//  refill request (cache2mem_upd_en/PC) to the memory controller, installs the
//  returned 32-bit word, then forwards it to ifetch. Halfword-indexed (PC[4:1]) so
//  RVC instructions at 2-byte boundaries hit independently.
// PARAMETERS
//  ADDR_WIDTH   32  PC / address width
//  INST_WIDTH   32  cached word width
//  INDEX_WIDTH  4   index bits, taken from PC[INDEX_WIDTH:1]; 2**INDEX_WIDTH lines
//  TAG_WIDTH    ADDR_WIDTH-INDEX_WIDTH-1 (derived localparam), PC[ADDR_WIDTH-1:INDEX_WIDTH+1]
// PORTS
//  clk              in   1   clock, posedge
//  rst_in_n         in   1   asynchronous active-low reset
//  rdy_in           in   1   global enable; 0 freezes all state
//  flush            in   1   pipeline flush (mispredict)
//  if_req_en        in   1   ifetch lookup request
//  if_pc            in   ADDR_WIDTH  lookup PC (bit 0 always 0)
//  if_inst_valid    out  1   1-cycle pulse: if_inst holds word for if_inst_pc
//  if_inst          out  INST_WIDTH  returned word
//  if_inst_pc       out  ADDR_WIDTH  PC of returned word
//  cache_busy       out  1   1 while a miss is outstanding (state MISS/RESP)
//  cache2mem_upd_en out  1   refill request, held until mem_rdy seen
//  cache2mem_PC     out  ADDR_WIDTH  refill address, stable while upd_en=1
//  mem_rdy          in   1   refill data valid (1-cycle)
//  mem2if_inst_out  in   INST_WIDTH  refill data
//  hit_cnt          out  32  (ICACHE_STATS_EN only) hit counter
//  miss_cnt         out  32  (ICACHE_STATS_EN only) miss counter
// BEHAVIOUR
//  - Storage: valid[], tag[], data[] per line. Reset: all valid=0, FSM=IDLE, all
//    outputs 0. Tag/data arrays need no reset.
//  - FSM IDLE: on if_req_en: compare valid[idx] && tag[idx]==if_pc tag.
//    Hit -> next cycle if_inst_valid=1, if_inst=data[idx], if_inst_pc=if_pc; stay IDLE.
//    Miss -> latch PC; next cycle cache2mem_upd_en=1, cache2mem_PC=PC; go MISS.
//  - MISS: hold upd_en/PC constant (memory may stall for LSB traffic, unbounded).
//    if_req_en ignored (ifetch holds PC). On mem_rdy: write data/tag, valid=1;
//    upd_en=0 next cycle; if_inst_valid=1 next cycle with mem2if_inst_out; -> IDLE.
//    upd_en must fall exactly the cycle after mem_rdy so memory does not restart.
//  - Accepting a new request the same cycle as the fill-forward is allowed
//    (back-to-back miss): new upd_en rises no earlier than 1 cycle after it fell.
//  - Simultaneous hit lookup and fill write never occur (IDLE vs MISS exclusive).
//  - flush (sync, priority over everything but reset): FSM->IDLE, upd_en=0,
//    if_inst_valid=0 next cycle, pending refill abandoned (no array write);
//    valid bits NOT cleared. mem_rdy arriving in IDLE is ignored.
//  - rdy_in=0: no state/output register changes; flush still takes effect only
//    when rdy_in=1 except reset. Async reset mid-miss -> IDLE, upd_en=0 immediately.
//  - Index wrap: PC[4:1]=15 and PC+2 map to distinct lines; no line-crossing logic.
// CONFIGURATION
//  ICACHE_STATS_EN defined: hit_cnt/miss_cnt ports exist; +1 per accepted hit/miss
//  lookup (not while rdy_in=0, flush cycle lookups not counted), wrap at 2**32,
//  reset to 0, not cleared by flush. Undefined: ports and counters absent.
// TESTING
//  1 reset, req PC=0x10 -> upd_en=1 PC=0x10 next cycle; mem_rdy data 0x00500093 ->
//    upd_en=0 and if_inst_valid with 0x00500093, pc 0x10 next cycle.
//  2 repeat req PC=0x10 -> if_inst_valid+0x00500093 1 cycle later, upd_en stays 0.
//  3 req PC=0x30 (same idx 8, new tag) -> miss/refill 0x00000013; then PC=0x10 misses again.
//  4 flush during MISS -> upd_en=0 next cycle; later mem_rdy ignored, no if_inst_valid;
//    PC=0x30 still hits.
//  5 rdy_in=0 for 5 cycles mid-miss -> outputs frozen; rst_in_n low mid-miss ->
//    upd_en=0 at once, subsequent PC=0x10 misses.
//  6 ICACHE_STATS_EN: sequence 1-3 -> hit_cnt=1, miss_cnt=3.

Source files
------------

// File: rtl/icache_direct_if.sv
// Ifetch lookup and memory refill signals of icache_direct, bundled as one interface.
// The slave modport is the cache's view; the master modport is the ifetch/memory side.
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  if_req_en;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  if_inst_valid;
  logic [INST_WIDTH-1:0] if_inst;
  logic [ADDR_WIDTH-1:0] if_inst_pc;
  logic                  cache_busy;
  logic                  cache2mem_upd_en;
  logic [ADDR_WIDTH-1:0] cache2mem_PC;
  logic                  mem_rdy;
  logic [INST_WIDTH-1:0] mem2if_inst_out;

  modport slave (
    input  if_req_en, if_pc, mem_rdy, mem2if_inst_out,
    output if_inst_valid, if_inst, if_inst_pc, cache_busy,
           cache2mem_upd_en, cache2mem_PC
  );

  modport master (
    output if_req_en, if_pc, mem_rdy, mem2if_inst_out,
    input  if_inst_valid, if_inst, if_inst_pc, cache_busy,
           cache2mem_upd_en, cache2mem_PC
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, halfword-indexed instruction cache with a single outstanding refill.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt lookup counters.
module icache_direct #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int INDEX_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_in_n,
  input  logic        rdy_in,
  input  logic        flush,
  icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 1;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic {
    IDLE,
    MISS
  } state_e;

  state_e                  state_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_WIDTH-1:0]    tag_q  [LINES];
  logic [INST_WIDTH-1:0]   data_q [LINES];

  logic                    upd_en_q;
  logic [ADDR_WIDTH-1:0]   mem_pc_q;
  logic                    busy_q;
  logic                    inst_valid_q;
  logic [INST_WIDTH-1:0]   inst_q;
  logic [ADDR_WIDTH-1:0]   inst_pc_q;

  logic [INDEX_WIDTH-1:0]  req_idx;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  fill_idx;
  logic [TAG_WIDTH-1:0]    fill_tag;
  logic                    lookup_hit;
  logic                    fill_we;

  assign req_idx  = bus.if_pc[INDEX_WIDTH:1];
  assign req_tag  = bus.if_pc[ADDR_WIDTH-1:INDEX_WIDTH+1];
  assign fill_idx = mem_pc_q[INDEX_WIDTH:1];
  assign fill_tag = mem_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+1];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A flush or a frozen pipeline abandons the refill data without touching the arrays.
  assign fill_we = rdy_in && !flush && (state_q == MISS) && bus.mem_rdy;

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      upd_en_q     <= 1'b0;
      mem_pc_q     <= '0;
      busy_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        state_q      <= IDLE;
        upd_en_q     <= 1'b0;
        busy_q       <= 1'b0;
        inst_valid_q <= 1'b0;
      end else begin
        inst_valid_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (bus.if_req_en) begin
              if (lookup_hit) begin
                inst_valid_q <= 1'b1;
                inst_q       <= data_q[req_idx];
                inst_pc_q    <= bus.if_pc;
              end else begin
                mem_pc_q <= bus.if_pc;
                upd_en_q <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= MISS;
              end
            end
          end
          MISS: begin
            // Request stays up until mem_rdy; dropping it the next cycle stops a restart.
            if (bus.mem_rdy) begin
              valid_q[fill_idx] <= 1'b1;
              upd_en_q          <= 1'b0;
              busy_q            <= 1'b0;
              inst_valid_q      <= 1'b1;
              inst_q            <= bus.mem2if_inst_out;
              inst_pc_q         <= mem_pc_q;
              state_q           <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether a line is usable,
  // so the arrays map onto plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem2if_inst_out;
    end
  end

  assign bus.if_inst_valid    = inst_valid_q;
  assign bus.if_inst          = inst_q;
  assign bus.if_inst_pc       = inst_pc_q;
  assign bus.cache_busy       = busy_q;
  assign bus.cache2mem_upd_en = upd_en_q;
  assign bus.cache2mem_PC     = mem_pc_q;

`ifdef ICACHE_STATS_EN
  logic        accept;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  assign accept = rdy_in && !flush && (state_q == IDLE) && bus.if_req_en;

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else            miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
